// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr} pairs. The head is a register of its own, so dout is
// registered and shows the oldest entry; flush beats push and pop.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  logic [63:0] din,
    output logic [63:0] dout,
    output logic [1:0]  count,
    output logic        empty,
    output logic        full
);

    logic [63:0] head_q, head_d;
    logic [63:0] tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic        do_push, do_pop;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign count = count_q;
    assign dout  = head_q;

    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd0) head_d = din;
                    else                 tail_d = din;
                end
                2'b01: begin
                    count_d = count_q - 2'd1;
                    head_d  = tail_q;
                end
                2'b11: begin
                    // Count unchanged; the new word lands behind whatever stays.
                    if (count_q == 2'd1) begin
                        head_d = din;
                    end else begin
                        head_d = tail_q;
                        tail_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= {32'h0000_0000, INSTR_NOP};
            tail_q  <= 64'h0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// RV32 fetch front end: PC register, next-PC mux and fetch FSM feeding a 2-entry
// {pc, instr} buffer towards decode; redirects flush the buffer.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        misalign
);

    localparam logic [31:0] IMEM_MASK = 32'(IMEM_BYTES - 1);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         misalign_q;
    logic         pop, fetch, buf_push, buf_pop;
    logic [63:0]  buf_dout;
    logic [1:0]   buf_count;
    logic         buf_empty, buf_full;

    assign imem_pc   = pc_q & IMEM_MASK;
    assign out_valid = ~buf_empty;
    assign out_pc    = buf_dout[63:32];
    assign out_instr = buf_dout[31:0];
    assign misalign  = misalign_q;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= redirect_valid & (|redirect_target[1:0]);
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                BOOT:    state_d = RUN;
                RUN:     if (halt) state_d = HALTED;
                HALTED:  state_d = HALTED;
                default: state_d = BOOT;
            endcase
        end
    end

    always_comb begin
        // A full buffer still takes a word when its head leaves in the same cycle.
        fetch    = (state_q == RUN) && (!buf_full || pop);
        buf_push = fetch & ~redirect_valid;
        buf_pop  = pop & ~redirect_valid;
        pc_d     = pc_q;
        if (redirect_valid) pc_d = {redirect_target[31:2], 2'b00};
        else if (fetch)     pc_d = pc_q + PC_STEP;
    end

    fetch_buffer u_buffer (
        .clk   (clk),
        .reset (reset),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (redirect_valid),
        .din   ({pc_q, imem_instr}),
        .dout  (buf_dout),
        .count (buf_count),
        .empty (buf_empty),
        .full  (buf_full)
    );

    logic unused_count;
    assign unused_count = ^buf_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected {pc, instr} deliveries go into a queue that
// a negedge monitor drains on every accepted handshake; point checks cover the rest.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        misalign;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [8];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_pc[4:2]];

    pc_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_pc         (imem_pc),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .misalign        (misalign)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted head must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready && !redirect_valid) begin
            logic [63:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got pc %h instr %h, expected nothing",
                         out_pc, out_instr);
            end else begin
                e = exp_q.pop_front();
                if ({out_pc, out_instr} !== e) begin
                    n_bad++;
                    $display("FAIL sb_word: got pc %h instr %h, expected pc %h instr %h",
                             out_pc, out_instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 32'h00940333; mem[1] = 32'h413903b3;
        mem[2] = 32'h035a02b3; mem[3] = 32'h00a00093;
        mem[4] = 32'h00b00113; mem[5] = 32'h01bd5f33;
        mem[6] = 32'h40c58633; mem[7] = 32'h00f768b3;
        reset = 1'b1; out_ready = 1'b1; halt = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h00000013);
        check("rst_misalign", {31'h0, misalign}, 32'd0);
        check("rst_imem_pc", imem_pc, 32'h0);

        // Run A: release reset, stream three words, then reset mid-run.
        tick(); reset = 1'b0;
        expect_word(32'h0, 32'h00940333);
        expect_word(32'h4, 32'h413903b3);
        expect_word(32'h8, 32'h035a02b3);
        @(negedge clk); check("boot_valid", {31'h0, out_valid}, 32'd0);
        tick(); @(negedge clk); check("fetch1_valid", {31'h0, out_valid}, 32'd0);
        tick(); @(negedge clk);
        check("c2_valid", {31'h0, out_valid}, 32'd1);
        check("c2_pc", out_pc, 32'h0);
        check("c2_instr", out_instr, 32'h00940333);
        tick(); @(negedge clk);
        check("c3_pc", out_pc, 32'h4);
        check("c3_instr", out_instr, 32'h413903b3);
        tick(); @(negedge clk); check("c4_pc", out_pc, 32'h8);
        tick(); reset = 1'b1; #1;
        check("midrst_valid", {31'h0, out_valid}, 32'd0);
        check("midrst_imem_pc", imem_pc, 32'h0);
        check("midrst_instr", out_instr, 32'h00000013);
        tick(); tick();

        // Run B: backpressure, redirects, wrap, halt.
        reset = 1'b0;
        expect_word(32'h00, 32'h00940333);
        expect_word(32'h04, 32'h413903b3);
        expect_word(32'h08, 32'h035a02b3);
        expect_word(32'h14, 32'h01bd5f33);
        expect_word(32'h1C, 32'h00f768b3);
        expect_word(32'h20, 32'h00940333);
        expect_word(32'h24, 32'h413903b3);
        expect_word(32'h08, 32'h035a02b3);
        tick();
        tick(); out_ready = 1'b0;
        @(negedge clk); check("bp_first_pc", out_pc, 32'h0);
        tick(); @(negedge clk); check("bp_stall_imem_pc", imem_pc, 32'h8);
        tick(); tick(); tick();
        @(negedge clk);
        check("bp_hold_valid", {31'h0, out_valid}, 32'd1);
        check("bp_hold_pc", out_pc, 32'h0);
        check("bp_hold_instr", out_instr, 32'h00940333);
        check("bp_hold_imem_pc", imem_pc, 32'h8);
        tick(); out_ready = 1'b1;
        tick(); tick();
        tick(); redirect_valid = 1'b1; redirect_target = 32'h14;
        tick(); redirect_valid = 1'b0;
        @(negedge clk); check("redir_bubble", {31'h0, out_valid}, 32'd0);
        tick(); @(negedge clk);
        check("redir_pc", out_pc, 32'h14);
        check("redir_instr", out_instr, 32'h01bd5f33);
        tick(); redirect_valid = 1'b1; redirect_target = 32'h1E;
        @(negedge clk); check("pre_misalign", {31'h0, misalign}, 32'd0);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        check("misalign_pulse", {31'h0, misalign}, 32'd1);
        check("misalign_bubble", {31'h0, out_valid}, 32'd0);
        check("aligned_imem_pc", imem_pc, 32'h1C);
        tick(); @(negedge clk);
        check("misalign_clear", {31'h0, misalign}, 32'd0);
        check("aligned_pc", out_pc, 32'h1C);
        check("aligned_instr", out_instr, 32'h00f768b3);
        check("wrap_imem_pc", imem_pc, 32'h0);
        tick(); halt = 1'b1;
        @(negedge clk);
        check("wrap_out_pc", out_pc, 32'h20);
        check("wrap_instr", out_instr, 32'h00940333);
        tick(); halt = 1'b0;
        @(negedge clk); check("halt_last_pc", out_pc, 32'h24);
        tick(); @(negedge clk);
        check("halt_drained", {31'h0, out_valid}, 32'd0);
        check("halt_imem_pc", imem_pc, 32'h8);
        tick(); redirect_valid = 1'b1; redirect_target = 32'h8;
        @(negedge clk); check("halt_still_empty", {31'h0, out_valid}, 32'd0);
        tick(); redirect_valid = 1'b0;
        @(negedge clk); check("resume_bubble", {31'h0, out_valid}, 32'd0);
        tick(); @(negedge clk);
        check("resume_pc", out_pc, 32'h8);
        check("resume_instr", out_instr, 32'h035a02b3);
        tick(); out_ready = 1'b0;
        tick(); tick();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
